// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file
// write port. ALU results that lose arbitration wait in a small in-order FIFO,
// and a starvation counter guarantees the FIFO eventually drains under a
// continuous stream of loads. Pending destination registers are reported to
// decode so it can stall on a source that has not been written yet.
module wb_arbiter #(
    parameter int BIT_WIDTH    = 32,
    parameter int REG_WIDTH    = 4,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_WIDTH-1:0] alu_dr,
    input  logic [BIT_WIDTH-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_WIDTH-1:0] mem_dr,
    input  logic [BIT_WIDTH-1:0] mem_data,
    input  logic [REG_WIDTH-1:0] sr1,
    input  logic [REG_WIDTH-1:0] sr2,
    output logic                 sr1_pend,
    output logic                 sr2_pend,
    output logic                 wrtEn,
    output logic [REG_WIDTH-1:0] dr,
    output logic [BIT_WIDTH-1:0] dIn
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage; entries carry no reset, validity comes from count/rd_ptr
    logic [REG_WIDTH-1:0] dr_mem   [DEPTH];
    logic [BIT_WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic fifo_empty;
    logic starved;
    logic forced;
    logic mem_win;
    logic pop;
    logic cut;
    logic push;

    // Arbitration: forced pop > load > FIFO head > ALU cut-through > idle
    assign fifo_empty = (count == '0);
    assign starved    = (starve_cnt == SW'(STARVE_LIMIT));
    assign forced     = starved && !fifo_empty;
    assign mem_ready  = !starved;
    assign alu_ready  = (count < CW'(DEPTH));
    assign mem_win    = mem_valid && mem_ready && !forced;
    assign pop        = forced || (!mem_win && !fifo_empty);
    assign cut        = !mem_win && fifo_empty && alu_valid;
    assign push       = alu_valid && alu_ready && !cut;

    // Per-entry occupancy and destination match for the hazard outputs
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset          = PW'(gi) - rd_ptr;
            assign entry_valid[gi] = ({1'b0, offset} < count);
            assign match1[gi]      = entry_valid[gi] && (dr_mem[gi] == sr1);
            assign match2[gi]      = entry_valid[gi] && (dr_mem[gi] == sr2);
        end
    endgenerate

    assign sr1_pend = (wrtEn && (dr == sr1)) || (|match1);
    assign sr2_pend = (wrtEn && (dr == sr2)) || (|match2);

    // FIFO payload write on push
    always_ff @(posedge clk) begin
        if (push) begin
            dr_mem[wr_ptr]   <= alu_dr;
            data_mem[wr_ptr] <= alu_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Starvation counter: counts load wins while ALU entries wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (mem_win && !starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Registered write port; dr/dIn hold their last value when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrtEn <= 1'b0;
            dr    <= '0;
            dIn   <= '0;
        end else if (pop) begin
            wrtEn <= 1'b1;
            dr    <= dr_mem[rd_ptr];
            dIn   <= data_mem[rd_ptr];
        end else if (mem_win) begin
            wrtEn <= 1'b1;
            dr    <= mem_dr;
            dIn   <= mem_data;
        end else if (cut) begin
            wrtEn <= 1'b1;
            dr    <= alu_dr;
            dIn   <= alu_data;
        end else begin
            wrtEn <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by a randomized
// interleave of ALU results and load bursts, all checked cycle by cycle
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_dr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_dr;
    logic [31:0] mem_data;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic        sr1_pend;
    logic        sr2_pend;
    logic        wrtEn;
    logic [3:0]  dr;
    logic [31:0] dIn;

    wb_arbiter #(
        .BIT_WIDTH(32), .REG_WIDTH(4), .DEPTH(4), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_dr(alu_dr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_dr(mem_dr), .mem_data(mem_data),
        .sr1(sr1), .sr2(sr2), .sr1_pend(sr1_pend), .sr2_pend(sr2_pend),
        .wrtEn(wrtEn), .dr(dr), .dIn(dIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: waiting ALU results, starvation count, expected port
    logic [3:0]  q_dr[$];
    logic [31:0] q_data[$];
    int          starve;
    logic        m_wen;
    logic [3:0]  m_dr;
    logic [31:0] m_din;
    bit          alu_acc;
    bit          mem_acc;

    // Observed writes during the randomized phase
    logic [3:0]  alu_log[$];
    int          mem_wr_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend_of(input logic [3:0] sr);
        bit p;
        p = m_wen && (m_dr == sr);
        foreach (q_dr[i]) if (q_dr[i] == sr) p = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        q_dr.delete();
        q_data.delete();
        starve = 0;
        m_wen  = 1'b0;
        m_dr   = '0;
        m_din  = '0;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_dr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dr = '0; mem_data = '0;
    endtask

    // One clock cycle: check combinational outputs, advance model, check port
    task automatic step();
        int qs;
        bit cut;
        #1;
        chk("alu_ready", alu_ready, q_dr.size() < 4);
        chk("mem_ready", mem_ready, starve != 4);
        chk("sr1_pend", sr1_pend, pend_of(sr1));
        chk("sr2_pend", sr2_pend, pend_of(sr2));
        qs      = q_dr.size();
        cut     = 1'b0;
        alu_acc = alu_valid && (qs < 4);
        mem_acc = mem_valid && (starve != 4);
        if ((starve == 4 && qs > 0) || (!mem_acc && qs > 0)) begin
            m_wen  = 1'b1;
            m_dr   = q_dr.pop_front();
            m_din  = q_data.pop_front();
            starve = 0;
        end else if (mem_acc) begin
            m_wen  = 1'b1;
            m_dr   = mem_dr;
            m_din  = mem_data;
            starve = (qs > 0) ? starve + 1 : 0;
        end else if (alu_valid) begin
            cut    = 1'b1;
            m_wen  = 1'b1;
            m_dr   = alu_dr;
            m_din  = alu_data;
            starve = 0;
        end else begin
            m_wen  = 1'b0;
            starve = 0;
        end
        if (alu_acc && !cut) begin
            q_dr.push_back(alu_dr);
            q_data.push_back(alu_data);
        end
        @(posedge clk);
        #1;
        chk("wrtEn", wrtEn, m_wen);
        chk("dr", dr, m_dr);
        chk("dIn", dIn, m_din);
        if (wrtEn === 1'b1) begin
            if (dr < 4'd10) alu_log.push_back(dr);
            else            mem_wr_cnt++;
        end
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 12; i++) step();
    endtask

    int  ai;
    int  mem_sent;
    int  burst_left;
    bit  alu_on;
    bit  mem_on;
    bit  done;

    initial begin
        reset = 1'b1;
        sr1 = '0; sr2 = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wrtEn", wrtEn, 0);
        chk("rst_dr", dr, 0);
        chk("rst_dIn", dIn, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);
        reset = 1'b0;
        $display("reset released");

        // ALU cut-through with empty FIFO
        alu_valid = 1'b1; alu_dr = 4'd3; alu_data = 32'h11;
        step();
        chk("t2_wrtEn", wrtEn, 1);
        chk("t2_dr", dr, 3);
        chk("t2_dIn", dIn, 32'h11);
        $display("txn cut-through dr=%0d dIn=%0h", dr, dIn);
        idle_inputs();
        step();

        // Same-cycle load and ALU: load first, ALU one cycle later
        mem_valid = 1'b1; mem_dr = 4'd5; mem_data = 32'hAA;
        alu_valid = 1'b1; alu_dr = 4'd6; alu_data = 32'hBB;
        sr1 = 4'd6; sr2 = 4'd5;
        step();
        chk("t3_c1_dr", dr, 5);
        chk("t3_c1_dIn", dIn, 32'hAA);
        idle_inputs();
        chk("t3_c1_pend", sr1_pend, 1);
        step();
        chk("t3_c2_dr", dr, 6);
        chk("t3_c2_dIn", dIn, 32'hBB);
        chk("t3_c2_pend", sr1_pend, 1);
        step();
        chk("t3_c3_wrtEn", wrtEn, 0);
        chk("t3_c3_pend", sr1_pend, 0);
        $display("txn same-cycle mem r5 then alu r6 done");

        // Load stream starves the FIFO until the forced pop
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_dr = 4'd12; mem_data = 32'h100 + i;
            alu_valid = 1'b1; alu_dr = 4'(i + 1); alu_data = 32'h200 + i;
            step();
        end
        chk("t4_full", alu_ready, 0);
        alu_valid = 1'b0;
        mem_data = 32'h1FF;
        step();
        chk("t4_starved", mem_ready, 0);
        step();
        chk("t4_forced_dr", dr, 1);
        chk("t4_forced_dIn", dIn, 32'h200);
        chk("t4_recover", mem_ready, 1);
        $display("txn forced pop dr=%0d dIn=%0h", dr, dIn);
        drain();

        // Asynchronous reset in the middle of a cycle with work pending
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_dr = 4'd13; mem_data = 32'h300 + i;
            alu_valid = 1'b1; alu_dr = 4'(7 + i); alu_data = 32'h400 + i;
            step();
        end
        #2 reset = 1'b1;
        #1;
        chk("t1_wrtEn", wrtEn, 0);
        chk("t1_dr", dr, 0);
        chk("t1_dIn", dIn, 0);
        chk("t1_alu_ready", alu_ready, 1);
        chk("t1_mem_ready", mem_ready, 1);
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1 reset = 1'b0;
        $display("txn mid-cycle reset");

        // Reset with three queued entries discards them
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_dr = 4'd14; mem_data = 32'h500 + i;
            alu_valid = 1'b1; alu_dr = 4'(2 + i); alu_data = 32'h600 + i;
            step();
        end
        sr1 = 4'd2; sr2 = 4'd4;
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("t5_pend1", sr1_pend, 0);
        chk("t5_pend2", sr2_pend, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_write", wrtEn, 0);
        end
        $display("txn reset with queued entries");

        // Randomized interleave of ten ALU results with load bursts
        alu_log.delete();
        mem_wr_cnt = 0;
        ai = 0; mem_sent = 0; burst_left = 0;
        alu_on = 1'b0; mem_on = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            if (!alu_on && ai < 10 && $urandom_range(1, 0) == 1) begin
                alu_on = 1'b1;
                alu_dr = 4'(ai);
                alu_data = $urandom;
            end
            if (burst_left == 0 && ai < 10 && $urandom_range(2, 0) == 0)
                burst_left = $urandom_range(6, 1);
            if (!mem_on && burst_left > 0) begin
                mem_on = 1'b1;
                mem_dr = 4'(10 + $urandom_range(5, 0));
                mem_data = $urandom;
            end
            alu_valid = alu_on;
            mem_valid = mem_on;
            sr1 = 4'($urandom_range(15, 0));
            sr2 = 4'($urandom_range(15, 0));
            step();
            if (alu_acc) begin
                alu_on = 1'b0;
                ai++;
            end
            if (mem_acc) begin
                mem_on = 1'b0;
                mem_sent++;
                burst_left--;
            end
            done = (ai == 10) && !alu_on && !mem_on && (burst_left == 0) && (q_dr.size() == 0);
        end
        chk("t6_timeout", done, 1);
        idle_inputs();
        step();
        step();
        chk("t6_alu_count", alu_log.size(), 10);
        for (int i = 0; i < alu_log.size() && i < 10; i++)
            chk("t6_alu_order", alu_log[i], i);
        chk("t6_mem_count", mem_wr_cnt, mem_sent);
        $display("txn random phase alu_writes=%0d mem_writes=%0d", alu_log.size(), mem_wr_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
